// File: rtl/mm_result_scan.sv
// mm_result_scan: sequences the result-select datapath.
// Drives the source select and clear strobe of the result/BCD block, then
// waits for its update pulse. In auto mode it rotates through the enabled
// sources with a programmable dwell; in manual mode it follows the switches.
module mm_result_scan #(
  parameter int DWELL_CYC   = 50000000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_en_i,
  input  logic [1:0] man_sel_i,
  input  logic       step_i,
  input  logic [3:0] src_mask_i,
  input  logic       res_update_i,
  output logic [1:0] sel_o,
  output logic       clr_o,
  output logic       valid_o,
  output logic       timeout_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  // Next enabled source after cur, scanning cur+1, cur+2, cur+3 (mod 4).
  // Result is {found, index}; the current source itself is never chosen.
  function automatic logic [2:0] find_next(input logic [1:0] cur,
                                           input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    // Walk from farthest to nearest so the nearest enabled source wins.
    for (int i = 3; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (mask[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       sel_r, sel_s;
  logic             clr_r, clr_s;
  logic             valid_r, valid_s;
  logic             tmo_r, tmo_s;
  logic [2:0]       nxt_s;

  assign sel_o     = sel_r;
  assign clr_o     = clr_r;
  assign valid_o   = valid_r;
  assign timeout_o = tmo_r;
  assign state_o   = state_r;

  // Next-state and next-output logic; every register's next value is decided here.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sel_s   = sel_r;
    clr_s   = 1'b0;
    valid_s = valid_r;
    tmo_s   = 1'b0;
    nxt_s   = find_next(sel_r, src_mask_i);

    case (state_r)
      ST_CLEAR: begin
        // Reset parks here with the strobe not yet issued; the first edge
        // out of reset issues it, so every CLEAR cycle carries clr_o=1.
        cnt_s   = CNT_ZERO;
        valid_s = 1'b0;
        if (clr_r) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_CLEAR;
          clr_s   = 1'b1;
        end
      end

      ST_WAIT: begin
        cnt_s = cnt_r + CNT_ONE;
        if (!auto_en_i && (man_sel_i != sel_r)) begin
          // A switch change outranks an update arriving in the same cycle.
          sel_s   = man_sel_i;
          state_s = ST_CLEAR;
          clr_s   = 1'b1;
          valid_s = 1'b0;
          cnt_s   = CNT_ZERO;
        end else if (res_update_i) begin
          valid_s = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = ST_DWELL;
        end else if (cnt_r == TMO_LAST) begin
          // Give up waiting but keep the display blanked.
          tmo_s   = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = ST_DWELL;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_DWELL: begin
        if (!auto_en_i) begin
          // Counter held at zero so a switch to auto starts a fresh dwell.
          cnt_s = CNT_ZERO;
          if (man_sel_i != sel_r) begin
            sel_s   = man_sel_i;
            state_s = ST_CLEAR;
            clr_s   = 1'b1;
            valid_s = 1'b0;
          end else begin
            state_s = ST_DWELL;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          if (step_i || (cnt_r == DWELL_LAST)) begin
            cnt_s = CNT_ZERO;
            if (nxt_s[2]) begin
              sel_s   = nxt_s[1:0];
              state_s = ST_CLEAR;
              clr_s   = 1'b1;
              valid_s = 1'b0;
            end else begin
              // Nothing else enabled: keep showing the current source.
              state_s = ST_DWELL;
            end
          end else begin
            state_s = ST_DWELL;
          end
        end
      end

      default: begin
        // Unused encoding: recover through a fresh clear.
        state_s = ST_CLEAR;
        cnt_s   = CNT_ZERO;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= CNT_ZERO;
      sel_r   <= 2'd0;
      clr_r   <= 1'b0;
      valid_r <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      clr_r   <= clr_s;
      valid_r <= valid_s;
      tmo_r   <= tmo_s;
    end
  end

endmodule

// File: tb/tb_mm_result_scan.sv
// Self-checking bench for mm_result_scan: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_mm_result_scan;

  localparam int DW = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       auto_en_i;
  logic [1:0] man_sel_i;
  logic       step_i;
  logic [3:0] src_mask_i;
  logic       res_update_i;
  logic [1:0] sel_o;
  logic       clr_o;
  logic       valid_o;
  logic       timeout_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: what the outputs should show this cycle.
  int m_sel, m_state, m_cnt;
  bit m_clr, m_valid, m_tmo;

  int sel_q[$];
  int dw_q[$];
  int nclr;

  always #5 clk = ~clk;

  mm_result_scan #(.DWELL_CYC(DW), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .auto_en_i(auto_en_i), .man_sel_i(man_sel_i),
    .step_i(step_i), .src_mask_i(src_mask_i), .res_update_i(res_update_i),
    .sel_o(sel_o), .clr_o(clr_o), .valid_o(valid_o), .timeout_o(timeout_o),
    .state_o(state_o)
  );

  function automatic int next_src(input int cur, input logic [3:0] mask);
    for (int k = 1; k <= 3; k++) begin
      if (mask[(cur + k) % 4]) return (cur + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit was_clr, go_clear;
    int tgt, n;
    was_clr  = m_clr;
    m_clr    = 1'b0;
    m_tmo    = 1'b0;
    go_clear = 1'b0;
    tgt      = m_sel;
    if (rst) begin
      m_sel = 0; m_valid = 1'b0; m_cnt = 0; m_state = 0;
      return;
    end
    case (m_state)
      0: begin
        m_cnt = 0; m_valid = 1'b0;
        if (was_clr) m_state = 1;
        else m_clr = 1'b1;
      end
      1: begin
        if (!auto_en_i && int'(man_sel_i) != m_sel) begin
          go_clear = 1'b1; tgt = int'(man_sel_i);
        end else if (res_update_i) begin
          m_valid = 1'b1; m_cnt = 0; m_state = 2;
        end else if (m_cnt == TO - 1) begin
          m_tmo = 1'b1; m_cnt = 0; m_state = 2;
        end else begin
          m_cnt++;
        end
      end
      2: begin
        if (!auto_en_i) begin
          m_cnt = 0;
          if (int'(man_sel_i) != m_sel) begin
            go_clear = 1'b1; tgt = int'(man_sel_i);
          end
        end else if (step_i || m_cnt == DW - 1) begin
          m_cnt = 0;
          n = next_src(m_sel, src_mask_i);
          if (n >= 0) begin
            go_clear = 1'b1; tgt = n;
          end
        end else begin
          m_cnt++;
        end
      end
      default: ;
    endcase
    if (go_clear) begin
      m_sel = tgt; m_state = 0; m_clr = 1'b1; m_valid = 1'b0; m_cnt = 0;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: DUT and model step on the same edge, compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checks++;
    assert ({sel_o, clr_o, valid_o, timeout_o, state_o} ===
            {2'(m_sel), m_clr, m_valid, m_tmo, 2'(m_state)}) else begin
      errors++;
      $error("FAIL cycle t=%0t: observed sel=%0d clr=%0b valid=%0b tmo=%0b st=%0d expected sel=%0d clr=%0b valid=%0b tmo=%0b st=%0d",
             $time, sel_o, clr_o, valid_o, timeout_o, state_o,
             m_sel, m_clr, m_valid, m_tmo, m_state);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Run with an update two cycles after every clear; record selects and dwell lengths.
  task automatic scan(input int want, input int max_cyc, input int since0);
    int since, dcount;
    bit have_seg;
    since = since0; dcount = 0; nclr = 0;
    have_seg = (since0 == 0);
    sel_q.delete(); dw_q.delete();
    for (int c = 0; c < max_cyc && nclr < want; c++) begin
      res_update_i = (since == 1);
      cyc();
      if (clr_o) begin
        if (have_seg) dw_q.push_back(dcount);
        sel_q.push_back(int'(sel_o));
        nclr++; dcount = 0; since = 0; have_seg = 1'b1;
      end else begin
        since++;
        if (state_o == 2'd2) dcount++;
      end
    end
    res_update_i = 1'b0;
  endtask

  initial begin
    int t, t2, extra_tmo;
    rst = 1'b1; auto_en_i = 1'b0; man_sel_i = 2'd0; step_i = 1'b0;
    src_mask_i = 4'd0; res_update_i = 1'b0;
    m_sel = 0; m_state = 0; m_cnt = 0; m_clr = 1'b0; m_valid = 1'b0; m_tmo = 1'b0;

    // Reset values, then a clear strobe and manual select flow.
    do_reset();
    chk("reset_state", int'(state_o), 0);
    chk("reset_clr", int'(clr_o), 0);
    cyc();
    chk("post_reset_clr", int'(clr_o), 1);
    cyc();
    chk("enter_wait", int'(state_o), 1);
    res_update_i = 1'b1; cyc(); res_update_i = 1'b0;
    chk("update_valid", int'(valid_o), 1);
    chk("update_dwell", int'(state_o), 2);
    cyc(); cyc();
    man_sel_i = 2'd2; cyc();
    chk("man_sel", int'(sel_o), 2);
    chk("man_clr", int'(clr_o), 1);
    chk("man_valid", int'(valid_o), 0);
    cyc();

    // Auto scan over all four sources.
    man_sel_i = 2'd0; do_reset();
    auto_en_i = 1'b1; src_mask_i = 4'b1111;
    scan(5, 200, 99);
    chk("scan_clears", nclr, 5);
    for (int i = 0; i < sel_q.size(); i++) chk("scan_sel", sel_q[i], i % 4);
    chk("scan_segs", dw_q.size(), 4);
    for (int i = 0; i < dw_q.size(); i++) chk("scan_dwell", dw_q[i], DW);

    // Sparse mask starting from source 1, then only the current source enabled.
    auto_en_i = 1'b0; man_sel_i = 2'd1; do_reset();
    cyc(); cyc(); cyc();
    chk("start_sel1", int'(sel_o), 1);
    chk("start_sel1_clr", int'(clr_o), 1);
    auto_en_i = 1'b1; src_mask_i = 4'b1010;
    scan(2, 100, 0);
    chk("mask1010_clears", nclr, 2);
    if (sel_q.size() == 2) begin
      chk("mask1010_sel0", sel_q[0], 3);
      chk("mask1010_sel1", sel_q[1], 1);
    end
    src_mask_i = 4'b0010;
    scan(1, 40, 0);
    chk("only_self_no_clr", nclr, 0);
    chk("only_self_sel", int'(sel_o), 1);
    chk("only_self_dwell", int'(state_o), 2);

    // Timeout with no update, then auto advance after a full dwell.
    man_sel_i = 2'd0; do_reset();
    auto_en_i = 1'b1; src_mask_i = 4'b1111;
    cyc(); cyc();
    chk("tmo_wait", int'(state_o), 1);
    t = 0;
    while (!timeout_o && t < 40) begin cyc(); t++; end
    chk("tmo_delay", t, TO);
    chk("tmo_valid", int'(valid_o), 0);
    t2 = 0; extra_tmo = 0;
    while (!clr_o && t2 < 40) begin
      cyc(); t2++;
      if (timeout_o) extra_tmo++;
    end
    chk("tmo_single_pulse", extra_tmo, 0);
    chk("tmo_advance_delay", t2, DW);
    chk("tmo_advance_sel", int'(sel_o), 1);

    // Step ends the dwell early in auto mode.
    cyc();
    res_update_i = 1'b1; cyc(); res_update_i = 1'b0;
    cyc(); cyc();
    step_i = 1'b1; cyc(); step_i = 1'b0;
    chk("step_clr", int'(clr_o), 1);
    chk("step_sel", int'(sel_o), 2);

    // Step is ignored in manual mode.
    auto_en_i = 1'b0; man_sel_i = 2'd2;
    cyc();
    res_update_i = 1'b1; cyc(); res_update_i = 1'b0;
    step_i = 1'b1; cyc(); step_i = 1'b0;
    chk("man_step_state", int'(state_o), 2);
    chk("man_step_clr", int'(clr_o), 0);

    // Switch change and update in the same WAIT cycle: switch wins.
    man_sel_i = 2'd1; cyc(); cyc();
    chk("prio_wait", int'(state_o), 1);
    man_sel_i = 2'd3; res_update_i = 1'b1; cyc(); res_update_i = 1'b0;
    chk("prio_state", int'(state_o), 0);
    chk("prio_sel", int'(sel_o), 3);
    chk("prio_valid", int'(valid_o), 0);

    // Reset in the middle of WAIT.
    cyc();
    for (int i = 0; i < 10; i++) cyc();
    chk("mid_wait", int'(state_o), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_sel", int'(sel_o), 0);
    chk("mid_rst_clr", int'(clr_o), 0);
    chk("mid_rst_state", int'(state_o), 0);
    man_sel_i = 2'd0; cyc();
    chk("mid_rst_clear", int'(clr_o), 1);
    chk("mid_rst_clear_sel", int'(sel_o), 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) auto_en_i = ~auto_en_i;
      if ($urandom_range(0, 39) == 0) man_sel_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) src_mask_i = 4'($urandom_range(0, 15));
      step_i       = ($urandom_range(0, 9) == 0);
      res_update_i = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
